reg_to_mem_store: RTL and testbench
===================================

// Module: reg_to_mem_store
// PURPOSE
//   Store path from register bank to data memory: the write-direction counterpart of the
//   writeback mux. Takes register B data plus the ALU-computed address and performs
//   SW / SH / SB on the word-addressed, little-endian data memory.
//   Sub-word stores are done as read-modify-write. Control unit holds in its store state until done.
// PARAMETERS
//   MEM_LATENCY  1  cycles from read address driven (mem_wr=0) to mem_rdata valid; legal 1..7
// PORTS
//   clk          in   1   rising-edge clock
//   reset_n      in   1   asynchronous active-low reset
//   start        in   1   store request; sampled only in IDLE
//   store_type   in   2   00=SW, 01=SH, 10=SB, 11=illegal
//   address      in   32  byte address (ALU output)
//   reg_data     in   32  register B value; low 16/8 bits used for SH/SB
//   mem_rdata    in   32  memory read word
//   mem_addr     out  32  word-aligned address {addr_q[31:2],2'b00}
//   mem_wdata    out  32  word to write
//   mem_wr       out  1   memory write strobe, one cycle
//   busy         out  1   high in every state except IDLE
//   done         out  1   one-cycle pulse, store finished (or aborted on fault)
//   fault        out  1   one-cycle pulse with done: illegal type or misaligned (see CONFIGURATION)
// BEHAVIOUR
//   Reset: state=IDLE; mem_addr=0, mem_wdata=0, mem_wr=0, busy=0, done=0, fault=0; latches cleared.
//   Reset asserted mid-operation aborts immediately; a write not yet strobed is never issued.
//   IDLE: start=1 latches address, store_type, reg_data. SW -> WRITE; SH/SB -> READ; type 11 -> DONE+fault.
//   READ: mem_addr driven, mem_wr=0; wait counter loads MEM_LATENCY-1 -> WAIT (or MERGE if latency 1).
//   WAIT: count down to 0 -> MERGE.
//   MERGE: capture mem_rdata; replace lane: SB lane=addr[1:0] with reg_data[7:0];
//          SH half=addr[1] with reg_data[15:0]; other bytes unchanged -> WRITE.
//   WRITE: mem_wr=1 for exactly one cycle, mem_wdata=merged word (SW: reg_data unmodified) -> DONE.
//   DONE: done=1 one cycle, busy=1 -> IDLE. New start accepted the cycle after DONE.
//   Latency start->done: SW 3 cycles (IDLE,WRITE,DONE edges); SH/SB 4+MEM_LATENCY cycles.
//   start while busy: ignored, not queued. Inputs may change after start accepted (latched).
//   mem_addr holds last value in IDLE; mem_wdata only meaningful when mem_wr=1.
//   Byte lanes: lane0=bits[7:0] (addr[1:0]=00) ... lane3=bits[31:24] (11).
// CONFIGURATION
//   STORE_ALIGN_CHECK_EN defined: SW with addr[1:0]!=00 or SH with addr[0]=1 skips memory access:
//     IDLE -> DONE, done=1 and fault=1 same cycle, mem_wr never asserted.
//   Not defined: low address bits silently ignored (SW writes aligned word, SH uses addr[1]);
//     fault asserts only for store_type=11.
// TESTING
//   1 SW: addr=0x0000_0010, reg_data=0xDEAD_BEEF -> one mem_wr, mem_addr=0x10, wdata=0xDEADBEEF, done 3 cycles after start.
//   2 SB: mem word=0x1122_3344, addr=0x12, reg_data=0xFFFF_FFAB -> wdata=0x11AB_3344, one read then one write.
//   3 SH: mem=0x1122_3344, addr=0x22, reg_data=0x0000_CAFE -> wdata=0xCAFE_3344; MEM_LATENCY=3 -> done at 7 cycles.
//   4 Misaligned SH addr=0x13 with STORE_ALIGN_CHECK_EN -> done=fault=1, no mem_wr; without macro -> wdata uses half 1.
//   5 store_type=11 -> done=fault=1 one cycle after start, no memory access; start while busy ignored.
//   6 reset_n low during WAIT of SB -> all outputs 0 immediately, no mem_wr; next start after release completes normally.

Source files
------------

// File: rtl/reg_to_mem_store_if.sv
// Store-path bundle: store request/status plus the word-addressed data memory port.
// The store unit uses the slave modport; the requester/memory side uses master.
interface reg_to_mem_store_if;
  logic        start;
  logic [1:0]  store_type;
  logic [31:0] address;
  logic [31:0] reg_data;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        fault;

  modport master (
    output start, store_type, address, reg_data, mem_rdata,
    input  mem_addr, mem_wdata, mem_wr, busy, done, fault
  );

  modport slave (
    input  start, store_type, address, reg_data, mem_rdata,
    output mem_addr, mem_wdata, mem_wr, busy, done, fault
  );
endinterface

// File: rtl/reg_to_mem_store.sv
// SW/SH/SB store unit for a word-addressed little-endian memory; sub-word stores use read-modify-write.
// Optional macro STORE_ALIGN_CHECK_EN: misaligned SW/SH abort with fault instead of silently aligning.
module reg_to_mem_store #(
  parameter int MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  reg_to_mem_store_if.slave   bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_MERGE, S_WRITE, S_DONE
  } state_t;

  localparam logic [1:0] T_SW = 2'b00;
  localparam logic [1:0] T_SH = 2'b01;
  localparam logic [1:0] T_SB = 2'b10;
  localparam logic [1:0] T_BAD = 2'b11;
  localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);

  state_t      r_state, w_state_next;
  logic [1:0]  r_type;
  logic [1:0]  r_addr_lo;
  logic [15:0] r_data;
  logic [2:0]  r_cnt;
  logic        r_fault;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] w_merged;
  logic        w_accept, w_misaligned, w_fault_req;
  logic        w_busy, w_done, w_mem_wr;

  assign w_accept = (r_state == S_IDLE) && bus.start;

`ifdef STORE_ALIGN_CHECK_EN
  assign w_misaligned = ((bus.store_type == T_SW) && (bus.address[1:0] != 2'b00)) ||
                        ((bus.store_type == T_SH) && bus.address[0]);
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_fault_req = (bus.store_type == T_BAD) || w_misaligned;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    w_mem_wr     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          if (w_fault_req)                  w_state_next = S_DONE;
          else if (bus.store_type == T_SW)  w_state_next = S_WRITE;
          else                              w_state_next = S_READ;
        end
      end
      S_READ:  w_state_next = (LAT_M1 == 3'd0) ? S_MERGE : S_WAIT;
      // r_cnt holds the WAIT cycles still to spend, including this one
      S_WAIT:  if (r_cnt == 3'd1) w_state_next = S_MERGE;
      S_MERGE: w_state_next = S_WRITE;
      S_WRITE: begin
        w_mem_wr     = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_merged = bus.mem_rdata;
    if (r_type == T_SB)
      w_merged[{r_addr_lo, 3'b000} +: 8] = r_data[7:0];
    else if (r_type == T_SH)
      w_merged[{r_addr_lo[1], 4'b0000} +: 16] = r_data[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_type      <= T_SW;
      r_addr_lo   <= 2'b00;
      r_data      <= 16'h0000;
      r_cnt       <= 3'd0;
      r_fault     <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
    end else begin
      if (w_accept) begin
        r_type     <= bus.store_type;
        r_addr_lo  <= bus.address[1:0];
        r_data     <= bus.reg_data[15:0];
        r_fault    <= w_fault_req;
        r_mem_addr <= {bus.address[31:2], 2'b00};
        // full-word stores skip the merge, so the write data is final right away
        if (bus.store_type == T_SW) r_mem_wdata <= bus.reg_data;
      end
      if (r_state == S_READ)      r_cnt <= LAT_M1;
      else if (r_state == S_WAIT) r_cnt <= r_cnt - 3'd1;
      if (r_state == S_MERGE) r_mem_wdata <= w_merged;
    end
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wr    = w_mem_wr;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.fault     = w_done & r_fault;
endmodule

// File: tb/tb_reg_to_mem_store.sv
// Directed bench for reg_to_mem_store: memory model with MEM_LATENCY read pipeline and a write scoreboard.
module tb_reg_to_mem_store;
  localparam int LAT = 3;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;

  wr_exp_t     exp_q[$];
  logic [31:0] mem    [0:63];
  logic [31:0] shadow [0:63];
  logic [31:0] rpipe  [0:LAT-1];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = 6'd0;
  logic [31:0] poke_val = 32'h0;

  reg_to_mem_store_if bus ();

  reg_to_mem_store #(.MEM_LATENCY(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (poke_en)         mem[poke_idx] <= poke_val;
    else if (bus.mem_wr) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    rpipe[0] <= mem[bus.mem_addr[7:2]];
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.mem_rdata = rpipe[LAT-1];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.mem_wr) begin
      wr_exp_t e;
      wr_count++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed addr=%h data=%h expected no write", bus.mem_addr, bus.mem_wdata);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", bus.mem_addr, e.addr);
        check("wr_data", bus.mem_wdata, e.data);
        $display("write addr=%h data=%h", bus.mem_addr, bus.mem_wdata);
      end
    end
  end

  function automatic logic [31:0] merge(logic [31:0] old, logic [1:0] t, logic [1:0] lo, logic [31:0] d);
    logic [31:0] r;
    r = old;
    case (t)
      2'b00: r = d;
      2'b01: if (lo[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      2'b10: case (lo)
               2'd0: r[7:0]   = d[7:0];
               2'd1: r[15:8]  = d[7:0];
               2'd2: r[23:16] = d[7:0];
               default: r[31:24] = d[7:0];
             endcase
      default: r = old;
    endcase
    return r;
  endfunction

  task automatic poke(logic [5:0] idx, logic [31:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    shadow[idx] = val;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic do_store(string tag, logic [1:0] t, logic [31:0] a, logic [31:0] d,
                          logic [31:0] exp_w, int exp_cyc, logic exp_fault, bit exp_write, bit poke_busy);
    int cyc;
    int wc;
    wr_exp_t e;
    wc = wr_count;
    if (exp_write) begin
      e.addr = {a[31:2], 2'b00};
      e.data = exp_w;
      exp_q.push_back(e);
      shadow[a[7:2]] = exp_w;
    end
    bus.start = 1'b1; bus.store_type = t; bus.address = a; bus.reg_data = d;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.address = $urandom; bus.reg_data = $urandom; bus.store_type = 2'($urandom);
    cyc = 1;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.done) break;
      if (poke_busy && cyc == 2) begin
        bus.start = 1'b1; bus.store_type = 2'b00; bus.address = 32'h3C; bus.reg_data = $urandom;
        @(posedge clk);
        #1 bus.start = 1'b0;
      end
    end
    check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_fault"}, {31'd0, bus.fault}, {31'd0, exp_fault});
    check({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd1);
    $display("store %s type=%0d addr=%h data=%h cycles=%0d fault=%b", tag, t, a, d, cyc, bus.fault);
    @(negedge clk);
    check({tag, "_writes"}, 32'(wr_count - wc), exp_write ? 32'd1 : 32'd0);
    check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  t;
    logic [5:0]  idx;
    logic [1:0]  lo;
    logic [31:0] d;
    int          wc;

    bus.start = 1'b0; bus.store_type = 2'b00; bus.address = 32'h0; bus.reg_data = 32'h0;
    #12;
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_fault", {31'd0, bus.fault}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    do_store("sw", 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3, 1'b0, 1'b1, 1'b0);

    poke(6'd4, 32'h1122_3344);
    do_store("sb", 2'b10, 32'h0000_0012, 32'hFFFF_FFAB, 32'h11AB_3344, 4 + LAT, 1'b0, 1'b1, 1'b0);

    poke(6'd8, 32'h1122_3344);
    do_store("sh", 2'b01, 32'h0000_0022, 32'h0000_CAFE, 32'hCAFE_3344, 4 + LAT, 1'b0, 1'b1, 1'b1);

    poke(6'd4, 32'h1122_3344);
`ifdef STORE_ALIGN_CHECK_EN
    do_store("sh_misaligned", 2'b01, 32'h0000_0013, 32'h0000_BEEF, 32'h0, 2, 1'b1, 1'b0, 1'b0);
    do_store("sw_misaligned", 2'b00, 32'h0000_0011, 32'h1234_5678, 32'h0, 2, 1'b1, 1'b0, 1'b0);
`else
    do_store("sh_misaligned", 2'b01, 32'h0000_0013, 32'h0000_BEEF, 32'hBEEF_3344, 4 + LAT, 1'b0, 1'b1, 1'b0);
    do_store("sw_misaligned", 2'b00, 32'h0000_0011, 32'h1234_5678, 32'h1234_5678, 3, 1'b0, 1'b1, 1'b0);
`endif

    do_store("illegal", 2'b11, 32'h0000_0020, 32'h5555_AAAA, 32'h0, 2, 1'b1, 1'b0, 1'b0);

    // Reset during WAIT of an SB: outputs clear at once and the write never happens
    poke(6'd12, 32'hA5A5_A5A5);
    @(negedge clk);
    wc = wr_count;
    bus.start = 1'b1; bus.store_type = 2'b10; bus.address = 32'h0000_0031; bus.reg_data = 32'h0000_0077;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_mem_addr", bus.mem_addr, 32'h0);
    check("abort_mem_wdata", bus.mem_wdata, 32'h0);
    check("abort_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_fault", {31'd0, bus.fault}, 32'd0);
    repeat (LAT + 4) @(negedge clk);
    reset_n = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    check("abort_writes", 32'(wr_count - wc), 32'd0);
    $display("reset abort during WAIT writes=%0d", wr_count - wc);
    do_store("sb_after_reset", 2'b10, 32'h0000_0031, 32'h0000_0077, 32'hA5A5_77A5, 4 + LAT, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      t   = 2'($urandom_range(0, 2));
      idx = 6'($urandom_range(16, 31));
      d   = $urandom;
      lo  = (t == 2'b00) ? 2'b00 : (t == 2'b01) ? {1'($urandom), 1'b0} : 2'($urandom);
      poke(idx, $urandom);
      do_store("rand", t, {24'd0, idx, lo}, d, merge(shadow[idx], t, lo, d),
               (t == 2'b00) ? 3 : 4 + LAT, 1'b0, 1'b1, 1'b0);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
